epu_dma: RTL and testbench

EPU_DMA -- requirements
Module: epu_dma

---
 rtl/epu_dma.sv | 190 +++++++++++++++++++
 tb/tb_epu_dma.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/epu_dma.sv
// epu_dma: single-channel AXI copy engine. Reads a burst into a local beat buffer,
// then writes it back out, looping until word_cnt words have moved.
module epu_dma #(
  parameter logic [3:0]  MST_ID    = 4'd2,
  parameter int unsigned MAX_BURST = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] src_addr,
  input  logic [31:0] dst_addr,
  input  logic [15:0] word_cnt,
  input  logic        dst_incr,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [3:0]  ARID,
  output logic [31:0] ARADDR,
  output logic [3:0]  ARLEN,
  output logic [2:0]  ARSIZE,
  output logic [1:0]  ARBURST,
  output logic        ARVALID,
  input  logic        ARREADY,
  input  logic [3:0]  RID,
  input  logic [31:0] RDATA,
  input  logic [1:0]  RRESP,
  input  logic        RLAST,
  input  logic        RVALID,
  output logic        RREADY,
  output logic [3:0]  AWID,
  output logic [31:0] AWADDR,
  output logic [3:0]  AWLEN,
  output logic [2:0]  AWSIZE,
  output logic [1:0]  AWBURST,
  output logic        AWVALID,
  input  logic        AWREADY,
  output logic [31:0] WDATA,
  output logic [3:0]  WSTRB,
  output logic        WLAST,
  output logic        WVALID,
  input  logic        WREADY,
  input  logic [3:0]  BID,
  input  logic [1:0]  BRESP,
  input  logic        BVALID,
  output logic        BREADY
);

  localparam int unsigned IW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, WR_RESP, DONE} state_t;

  state_t        state;
  logic [31:0]   src_q, dst_q;
  logic [15:0]   rem_q;
  logic          incr_q;
  logic [IW-1:0] beat, wbeat;
  logic [31:0]   buf_mem [MAX_BURST];
  logic [10:0]   src_room, dst_room;
  logic [16:0]   blen, blen_m1;
  logic          rd_bad;
  logic          unused_ok;

  // Burst length is derived from registered state, which only changes in WR_RESP,
  // so it is stable for the whole read/write burst pair.
  always_comb begin
    src_room = 11'd1024 - {1'b0, src_q[11:2]};
    dst_room = 11'd1024 - {1'b0, dst_q[11:2]};
    blen     = 17'(MAX_BURST);
    if ({1'b0, rem_q} < blen)              blen = {1'b0, rem_q};
    if ({6'b0, src_room} < blen)           blen = {6'b0, src_room};
    if (incr_q && ({6'b0, dst_room} < blen)) blen = {6'b0, dst_room};
    blen_m1 = blen - 17'd1;
  end

  assign rd_bad    = (RRESP != 2'b00) || (RLAST && (17'(beat) != blen_m1));
  assign unused_ok = ^{RID, BID, src_addr[1:0], dst_addr[1:0]};

  assign ARID    = MST_ID;
  assign AWID    = MST_ID;
  assign ARADDR  = src_q;
  assign AWADDR  = dst_q;
  assign ARLEN   = blen_m1[3:0];
  assign AWLEN   = blen_m1[3:0];
  assign ARSIZE  = 3'b010;
  assign AWSIZE  = 3'b010;
  assign ARBURST = 2'b01;
  assign AWBURST = incr_q ? 2'b01 : 2'b00;
  assign WSTRB   = 4'hF;
  assign WDATA   = buf_mem[wbeat];
  assign WLAST   = WVALID && (17'(wbeat) == blen_m1);

  always_ff @(posedge clk) begin
    if (state == RD_DATA && RVALID) buf_mem[beat] <= RDATA;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      incr_q  <= 1'b0;
      beat    <= '0;
      wbeat   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      ARVALID <= 1'b0;
      RREADY  <= 1'b0;
      AWVALID <= 1'b0;
      WVALID  <= 1'b0;
      BREADY  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          src_q  <= {src_addr[31:2], 2'b00};
          dst_q  <= dst_incr ? {dst_addr[31:2], 2'b00} : 32'h0010_0000;
          rem_q  <= word_cnt;
          incr_q <= dst_incr;
          err    <= 1'b0;
          busy   <= 1'b1;
          if (word_cnt == 16'd0) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state   <= RD_ADDR;
            ARVALID <= 1'b1;
          end
        end
        RD_ADDR: if (ARREADY) begin
          ARVALID <= 1'b0;
          RREADY  <= 1'b1;
          beat    <= '0;
          state   <= RD_DATA;
        end
        RD_DATA: if (RVALID) begin
          beat <= beat + IW'(1);
          if (rd_bad) err <= 1'b1;
          if (RLAST) begin
            RREADY <= 1'b0;
            // A bad burst is drained to RLAST but never written out.
            if (err || rd_bad) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state   <= WR_ADDR;
              AWVALID <= 1'b1;
            end
          end
        end
        WR_ADDR: if (AWREADY) begin
          AWVALID <= 1'b0;
          WVALID  <= 1'b1;
          wbeat   <= '0;
          state   <= WR_DATA;
        end
        WR_DATA: if (WREADY) begin
          if (WLAST) begin
            WVALID <= 1'b0;
            BREADY <= 1'b1;
            state  <= WR_RESP;
          end else begin
            wbeat <= wbeat + IW'(1);
          end
        end
        WR_RESP: if (BVALID) begin
          BREADY <= 1'b0;
          rem_q  <= rem_q - blen[15:0];
          src_q  <= src_q + (32'(blen) << 2);
          if (incr_q) dst_q <= dst_q + (32'(blen) << 2);
          if (({1'b0, rem_q} == blen) || (BRESP != 2'b00)) begin
            if (BRESP != 2'b00) err <= 1'b1;
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state   <= RD_ADDR;
            ARVALID <= 1'b1;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_epu_dma.sv
// Directed bench for epu_dma: a cycle-driven AXI slave responder plus one task per scenario.
module tb_epu_dma;

  logic        clk = 1'b0;
  logic        rst, start, dst_incr;
  logic [31:0] src_addr, dst_addr;
  logic [15:0] word_cnt;
  logic        busy, done, err;
  logic [3:0]  ARID, ARLEN, RID, AWID, AWLEN, WSTRB, BID;
  logic [31:0] ARADDR, RDATA, AWADDR, WDATA;
  logic [2:0]  ARSIZE, AWSIZE;
  logic [1:0]  ARBURST, RRESP, AWBURST, BRESP;
  logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;
  logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;

  int compared = 0;
  int mismatched = 0;

  // observations of the last run_xfer
  int n_ar, n_aw, n_w, n_done, data_bad, last_bad, stab_bad, attr_bad, lap_bad, valid_cnt, done_cyc;
  logic [31:0] ar_a [8];
  logic [3:0]  ar_l [8];
  logic [31:0] aw_a [8];
  logic [3:0]  aw_l [8];
  logic [1:0]  aw_b [8];
  logic        err_at_done, busy_at_done, busy_after;
  bit          timed_out;

  always #5 clk = ~clk;

  epu_dma #(.MST_ID(4'd2), .MAX_BURST(16)) dut (
    .clk(clk), .rst(rst), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
    .word_cnt(word_cnt), .dst_incr(dst_incr), .busy(busy), .done(done), .err(err),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .RID(RID), .RDATA(RDATA), .RRESP(RRESP),
    .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY), .AWID(AWID), .AWADDR(AWADDR),
    .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  function automatic logic rnd_ready(input bit bp);
    return bp ? 1'($urandom_range(0, 1)) : 1'b1;
  endfunction

  // Acts as the AXI slave: all decisions are made on the falling edge for the next rising edge.
  task automatic run_xfer(input logic [31:0] sa, input logic [31:0] da, input logic [15:0] wc,
                          input logic inc, input bit bp, input bit poke, input int err_beat);
    bit rd_active = 0, wr_active = 0, b_active = 0, r_hs = 0, b_hs = 0;
    bit ar_wait = 0, aw_wait = 0, w_wait = 0, seen_done = 0;
    logic [31:0] r_addr = '0, p_araddr = '0, p_awaddr = '0, p_wdata = '0;
    logic [3:0]  p_arlen = '0, p_awlen = '0;
    logic        p_wlast = 1'b0;
    int r_i = 0, r_len = 0, r_glob = 0, w_i = 0, w_len = 0, post = 0;
    logic [31:0] sa_al;
    sa_al = {sa[31:2], 2'b00};
    n_ar = 0; n_aw = 0; n_w = 0; n_done = 0; data_bad = 0; last_bad = 0; stab_bad = 0;
    attr_bad = 0; lap_bad = 0; valid_cnt = 0; done_cyc = -1; timed_out = 0;
    err_at_done = 1'b0; busy_at_done = 1'b0; busy_after = 1'b1;
    @(negedge clk);
    src_addr = sa; dst_addr = da; word_cnt = wc; dst_incr = inc; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (poke && cyc == 3) begin start = 1'b1; word_cnt = 16'd7; src_addr = 32'h0000_8000; end
      if (poke && cyc == 4) start = 1'b0;
      if (ARVALID || AWVALID || WVALID) valid_cnt++;
      if (seen_done) begin
        if (post == 0) busy_after = busy;
        post++;
      end
      if (done) begin
        n_done++;
        if (!seen_done) begin
          seen_done = 1; done_cyc = cyc; err_at_done = err; busy_at_done = busy;
        end
      end
      if (post >= 3) break;
      // read data
      if (r_hs) begin RVALID = 1'b0; r_hs = 0; end
      if (rd_active && !RVALID && rnd_ready(bp)) begin
        RVALID = 1'b1;
        RDATA  = mem_word(r_addr + 32'(r_i * 4));
        RLAST  = (r_i == r_len);
        RRESP  = (r_glob == err_beat) ? 2'b10 : 2'b00;
      end
      if (RVALID && RREADY) begin
        r_hs = 1; r_i++; r_glob++;
        if (RLAST) rd_active = 0;
      end
      // read address
      if (ar_wait && (ARVALID !== 1'b1 || ARADDR !== p_araddr || ARLEN !== p_arlen)) stab_bad++;
      ARREADY = rnd_ready(bp);
      if (ARVALID && ARREADY) begin
        if (n_ar < 8) begin ar_a[n_ar] = ARADDR; ar_l[n_ar] = ARLEN; end
        n_ar++;
        if (rd_active || wr_active) lap_bad++;
        if (ARSIZE !== 3'b010 || ARBURST !== 2'b01 || ARID !== 4'd2) attr_bad++;
        rd_active = 1; r_i = 0; r_len = int'(ARLEN); r_addr = ARADDR;
      end
      ar_wait = ARVALID && !ARREADY; p_araddr = ARADDR; p_arlen = ARLEN;
      // write response
      if (b_hs) begin BVALID = 1'b0; b_hs = 0; end
      if (b_active && !BVALID && rnd_ready(bp)) begin BVALID = 1'b1; BRESP = 2'b00; end
      if (BVALID && BREADY) begin b_hs = 1; b_active = 0; wr_active = 0; end
      // write address
      if (aw_wait && (AWVALID !== 1'b1 || AWADDR !== p_awaddr || AWLEN !== p_awlen)) stab_bad++;
      AWREADY = rnd_ready(bp);
      if (AWVALID && AWREADY) begin
        if (n_aw < 8) begin aw_a[n_aw] = AWADDR; aw_l[n_aw] = AWLEN; aw_b[n_aw] = AWBURST; end
        n_aw++;
        if (rd_active) lap_bad++;
        if (AWSIZE !== 3'b010 || AWID !== 4'd2) attr_bad++;
        wr_active = 1; w_i = 0; w_len = int'(AWLEN);
      end
      aw_wait = AWVALID && !AWREADY; p_awaddr = AWADDR; p_awlen = AWLEN;
      // write data
      if (w_wait && (WVALID !== 1'b1 || WDATA !== p_wdata || WLAST !== p_wlast)) stab_bad++;
      WREADY = rnd_ready(bp);
      if (WVALID && WREADY) begin
        if (WDATA !== mem_word(sa_al + 32'(n_w * 4))) data_bad++;
        if (WLAST !== (w_i == w_len)) last_bad++;
        if (WSTRB !== 4'hF) attr_bad++;
        n_w++; w_i++;
        if (WLAST) b_active = 1;
      end
      w_wait = WVALID && !WREADY; p_wdata = WDATA; p_wlast = WLAST;
      @(negedge clk);
    end
    if (!seen_done) timed_out = 1;
    ARREADY = 1'b0; RVALID = 1'b0; RLAST = 1'b0; RRESP = 2'b00;
    AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #3;
    compared++;
    if ({busy, done, err, ARVALID, RREADY, AWVALID, WVALID, WLAST, BREADY} !== 9'b0) begin
      mismatched++;
      $display("FAIL reset_outputs got %b want 000000000",
               {busy, done, err, ARVALID, RREADY, AWVALID, WVALID, WLAST, BREADY});
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_fixed_dst();
    run_xfer(32'h0000_2000, 32'h0000_5550, 16'd5, 1'b0, 1'b0, 1'b0, -1);
    compared++; if (timed_out) begin mismatched++; $display("FAIL fixed.timeout got 1 want 0"); end
    compared++; if (n_ar !== 1) begin mismatched++; $display("FAIL fixed.n_ar got %0d want 1", n_ar); end
    compared++; if (ar_a[0] !== 32'h2000 || ar_l[0] !== 4'd4) begin mismatched++;
      $display("FAIL fixed.ar got %h/%0d want 00002000/4", ar_a[0], ar_l[0]); end
    compared++; if (n_aw !== 1) begin mismatched++; $display("FAIL fixed.n_aw got %0d want 1", n_aw); end
    compared++; if (aw_a[0] !== 32'h0010_0000 || aw_l[0] !== 4'd4 || aw_b[0] !== 2'b00) begin mismatched++;
      $display("FAIL fixed.aw got %h/%0d/%0d want 00100000/4/0", aw_a[0], aw_l[0], aw_b[0]); end
    compared++; if (n_w !== 5 || data_bad !== 0 || last_bad !== 0) begin mismatched++;
      $display("FAIL fixed.wdata got n_w=%0d bad=%0d lastbad=%0d want 5/0/0", n_w, data_bad, last_bad); end
    compared++; if (n_done !== 1 || err_at_done !== 1'b0) begin mismatched++;
      $display("FAIL fixed.done got n_done=%0d err=%b want 1/0", n_done, err_at_done); end
    compared++; if (busy_at_done !== 1'b1 || busy_after !== 1'b0) begin mismatched++;
      $display("FAIL fixed.busy got %b%b want 10", busy_at_done, busy_after); end
    compared++; if (attr_bad !== 0) begin mismatched++; $display("FAIL fixed.attr got %0d want 0", attr_bad); end
  endtask

  task automatic test_multi_burst();
    logic [31:0] ea [3] = '{32'h1000, 32'h1040, 32'h1080};
    logic [31:0] ew [3] = '{32'h3000, 32'h3040, 32'h3080};
    logic [3:0]  el [3] = '{4'd15, 4'd15, 4'd7};
    run_xfer(32'h0000_1000, 32'h0000_3000, 16'd40, 1'b1, 1'b0, 1'b1, -1);
    compared++; if (n_ar !== 3 || n_aw !== 3) begin mismatched++;
      $display("FAIL multi.count got ar=%0d aw=%0d want 3/3", n_ar, n_aw); end
    for (int i = 0; i < 3; i++) begin
      compared++;
      if (ar_a[i] !== ea[i] || ar_l[i] !== el[i] || aw_a[i] !== ew[i] || aw_l[i] !== el[i] || aw_b[i] !== 2'b01) begin
        mismatched++;
        $display("FAIL multi.burst%0d got ar=%h/%0d aw=%h/%0d/%0d want %h/%0d %h/%0d/1",
                 i, ar_a[i], ar_l[i], aw_a[i], aw_l[i], aw_b[i], ea[i], el[i], ew[i], el[i]);
      end
    end
    compared++; if (n_w !== 40 || data_bad !== 0 || last_bad !== 0 || lap_bad !== 0) begin mismatched++;
      $display("FAIL multi.data got n_w=%0d bad=%0d last=%0d lap=%0d want 40/0/0/0", n_w, data_bad, last_bad, lap_bad); end
    compared++; if (n_done !== 1) begin mismatched++; $display("FAIL multi.done got %0d want 1", n_done); end
  endtask

  task automatic test_4k_boundary();
    run_xfer(32'h0000_0FF8, 32'h0000_8000, 16'd4, 1'b1, 1'b0, 1'b0, -1);
    compared++; if (n_ar !== 2 || ar_a[0] !== 32'h0FF8 || ar_l[0] !== 4'd1 || ar_a[1] !== 32'h1000 || ar_l[1] !== 4'd1) begin
      mismatched++; $display("FAIL src4k.ar got n=%0d %h/%0d %h/%0d want 2 00000ff8/1 00001000/1",
                             n_ar, ar_a[0], ar_l[0], ar_a[1], ar_l[1]); end
    compared++; if (n_aw !== 2 || aw_a[1] !== 32'h8008 || n_w !== 4 || data_bad !== 0) begin
      mismatched++; $display("FAIL src4k.w got n_aw=%0d aw1=%h n_w=%0d bad=%0d want 2/00008008/4/0",
                             n_aw, aw_a[1], n_w, data_bad); end
    run_xfer(32'h0000_0000, 32'h0000_1FF4, 16'd8, 1'b1, 1'b0, 1'b0, -1);
    compared++; if (n_ar !== 2 || ar_l[0] !== 4'd2 || ar_a[1] !== 32'h000C || ar_l[1] !== 4'd4) begin
      mismatched++; $display("FAIL dst4k.ar got n=%0d len0=%0d %h/%0d want 2 2 0000000c/4",
                             n_ar, ar_l[0], ar_a[1], ar_l[1]); end
    compared++; if (n_aw !== 2 || aw_a[0] !== 32'h1FF4 || aw_l[0] !== 4'd2 || aw_a[1] !== 32'h2000 || aw_l[1] !== 4'd4) begin
      mismatched++; $display("FAIL dst4k.aw got n=%0d %h/%0d %h/%0d want 2 00001ff4/2 00002000/4",
                             n_aw, aw_a[0], aw_l[0], aw_a[1], aw_l[1]); end
  endtask

  task automatic test_back_pressure();
    run_xfer(32'h0000_4000, 32'h0000_6000, 16'd20, 1'b1, 1'b1, 1'b0, -1);
    compared++; if (timed_out || n_done !== 1) begin mismatched++;
      $display("FAIL bp.done got timeout=%0d n_done=%0d want 0/1", timed_out, n_done); end
    compared++; if (stab_bad !== 0) begin mismatched++; $display("FAIL bp.stable got %0d want 0", stab_bad); end
    compared++; if (n_w !== 20 || data_bad !== 0) begin mismatched++;
      $display("FAIL bp.data got n_w=%0d bad=%0d want 20/0", n_w, data_bad); end
    compared++; if (last_bad !== 0 || lap_bad !== 0) begin mismatched++;
      $display("FAIL bp.wlast got last=%0d lap=%0d want 0/0", last_bad, lap_bad); end
    compared++; if (n_aw !== 2 || aw_a[1] !== 32'h6040 || aw_l[0] !== 4'd15 || aw_l[1] !== 4'd3) begin mismatched++;
      $display("FAIL bp.aw got n=%0d a1=%h l0=%0d l1=%0d want 2/00006040/15/3", n_aw, aw_a[1], aw_l[0], aw_l[1]); end
  endtask

  task automatic test_read_error();
    run_xfer(32'h0000_2000, 32'h0000_3000, 16'd5, 1'b1, 1'b0, 1'b0, 2);
    compared++; if (err_at_done !== 1'b1) begin mismatched++; $display("FAIL rderr.err got %b want 1", err_at_done); end
    compared++; if (n_aw !== 0 || n_w !== 0) begin mismatched++;
      $display("FAIL rderr.nowrite got aw=%0d w=%0d want 0/0", n_aw, n_w); end
    compared++; if (n_ar !== 1 || n_done !== 1) begin mismatched++;
      $display("FAIL rderr.done got ar=%0d done=%0d want 1/1", n_ar, n_done); end
  endtask

  task automatic test_zero_count();
    run_xfer(32'h0000_2000, 32'h0000_3000, 16'd0, 1'b1, 1'b0, 1'b0, -1);
    compared++; if (done_cyc !== 0 || n_done !== 1) begin mismatched++;
      $display("FAIL zero.done got cyc=%0d n=%0d want 0/1", done_cyc, n_done); end
    compared++; if (valid_cnt !== 0) begin mismatched++; $display("FAIL zero.novalid got %0d want 0", valid_cnt); end
    compared++; if (err_at_done !== 1'b0) begin mismatched++; $display("FAIL zero.err_cleared got %b want 0", err_at_done); end
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    src_addr = 32'h2000; dst_addr = 32'h3000; word_cnt = 16'd5; dst_incr = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    compared++; if (ARVALID !== 1'b1) begin mismatched++; $display("FAIL midrst.arvalid_pre got %b want 1", ARVALID); end
    #2 rst = 1'b0;
    #1;
    compared++; if ({busy, done, err, ARVALID, RREADY, AWVALID, WVALID, WLAST, BREADY} !== 9'b0) begin
      mismatched++;
      $display("FAIL midrst.async got %b want 000000000",
               {busy, done, err, ARVALID, RREADY, AWVALID, WVALID, WLAST, BREADY});
    end
    @(negedge clk); rst = 1'b1; ARREADY = 1'b1;
    repeat (4) @(negedge clk);
    compared++; if (ARVALID !== 1'b0 || busy !== 1'b0) begin mismatched++;
      $display("FAIL midrst.idle got arvalid=%b busy=%b want 0/0", ARVALID, busy); end
    ARREADY = 1'b0;
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; src_addr = '0; dst_addr = '0; word_cnt = '0; dst_incr = 1'b0;
    ARREADY = 1'b0; RID = 4'd2; RDATA = '0; RRESP = 2'b00; RLAST = 1'b0; RVALID = 1'b0;
    AWREADY = 1'b0; WREADY = 1'b0; BID = 4'd2; BRESP = 2'b00; BVALID = 1'b0;
    test_reset();
    test_fixed_dst();
    test_multi_burst();
    test_4k_boundary();
    test_back_pressure();
    test_read_error();
    test_zero_count();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
